// File: rtl/sumador_serial.sv
// Bit-serial adder: one full-adder stage walks both operands LSB first,
// recirculating its carry, and publishes the WIDTH-bit result with carry/overflow flags.
module sumador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] opa_p0;
  logic [WIDTH-1:0] opb_p0;
  logic [WIDTH-1:0] acc_p0;
  logic             carry_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic [1:0] fa;
  logic       last_bit;

  // Returns {carry, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  assign fa       = full_add(opa_p0[0], opb_p0[0], carry_p0);
  assign last_bit = (cnt_p0 == LAST);

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      opa_p0   <= '0;
      opb_p0   <= '0;
      acc_p0   <= '0;
      carry_p0 <= 1'b0;
      cnt_p0   <= '0;
      Sum      <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      // Stage 0: operand capture on the accepting edge
      if (state == IDLE && Start) begin
        opa_p0   <= OperandA;
        opb_p0   <= OperandB;
        carry_p0 <= CarryIn;
        cnt_p0   <= '0;
      end
      // Stage 1: one bit pair per edge, sum bits enter the accumulator at the MSB
      if (state == ADD) begin
        opa_p0   <= opa_p0 >> 1;
        opb_p0   <= opb_p0 >> 1;
        acc_p0   <= {fa[0], acc_p0[WIDTH-1:1]};
        carry_p0 <= fa[1];
        cnt_p0   <= cnt_p0 + 1'b1;
        // carry_p0 still holds the carry into the MSB on this edge
        if (last_bit) begin
          Sum      <= {fa[0], acc_p0[WIDTH-1:1]};
          CarryOut <= fa[1];
          Overflow <= carry_p0 ^ fa[1];
        end
      end
    end
  end

endmodule

// File: doc/sumador_serial.md
Name: sumador_serial

Overview:
- Bit-serial adder built around a single one-bit full-adder stage.
- Loads two WIDTH-bit operands and feeds the stage one bit pair per clock, LSB first, from shift registers.
- Registers the stage's carry output and feeds it back as the next carry input.
- Assembles the stage's sum bits into a WIDTH-bit result; used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
Clk  input  1  single system clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request to begin an addition; sampled only in IDLE.
OperandA  input  WIDTH  first addend; captured on the accepting edge.
OperandB  input  WIDTH  second addend; captured on the accepting edge.
CarryIn  input  1  initial carry; captured on the accepting edge.
Busy  output  1  high in ADD and DONE states.
Done  output  1  one-cycle pulse: result valid.
Sum  output  WIDTH  result; held stable from Done until next accepted Start.
CarryOut  output  1  final carry out of MSB; held like Sum.
Overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB); held like Sum.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - State goes to IDLE.
  - Busy, Done, Sum, CarryOut and Overflow go to 0.
  - Shift registers, carry register and bit counter are cleared.
  - An interrupted operation never produces Done.
- States:
  - IDLE: Busy=0, Done=0.
  - ADD: Busy=1.
  - DONE: Busy=1, Done=1, lasts exactly one cycle.
- IDLE -> ADD on an edge where Start=1. On that edge:
  - OperandA and OperandB load into shift registers.
  - The carry register loads CarryIn.
  - The bit counter clears to 0.
  - Sum, CarryOut and Overflow keep their previous values until the new result is ready.
- ADD, each edge:
  - The full adder combines the LSBs of both shift registers with the carry register.
  - The sum bit shifts into Sum-accumulator bit WIDTH-1 while the accumulator shifts right.
  - Both operand registers shift right.
  - The carry register takes the stage's carry output.
  - The counter increments.
- Carry into MSB: on the edge where counter = WIDTH-1, the carry register value (before update) is saved as the carry into the MSB.
- ADD -> DONE on the edge where counter = WIDTH-1 (the WIDTH-th ADD edge). On that edge:
  - Sum takes the full accumulator.
  - CarryOut takes the final carry.
  - Overflow = saved carry into MSB XOR final carry.
- DONE -> IDLE unconditionally on the next edge. Outputs stay held.
- Latency: if Start is accepted at edge k, Done is high during the cycle following edge k+WIDTH. A new Start can be accepted no earlier than edge k+WIDTH+2.
- Start rules:
  - Start in ADD or DONE is ignored; it is not queued.
  - Start held high continuously restarts on every IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
- Operand and CarryIn changes outside the accepting edge have no effect.
- Arithmetic is modulo 2^WIDTH. CarryOut is bit WIDTH of the unsigned sum OperandA + OperandB + CarryIn.
- Reset and Start asserted together: Reset wins.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, CarryIn=0 -> Done exactly 8 cycles after the accepting edge; Sum=0x96, CarryOut=0, Overflow=1.
- A=0xFF, B=0x01, CarryIn=0 -> Sum=0x00, CarryOut=1, Overflow=0. Then A=0xFF, B=0xFF, CarryIn=1 -> Sum=0xFF, CarryOut=1, Overflow=0.
- A=0x80, B=0x80, CarryIn=0 -> Sum=0x00, CarryOut=1, Overflow=1. Sum holds 0x00 for 20 IDLE cycles while operand inputs toggle randomly.
- Start with A=0x01, B=0x02, then Start pulses and operand changes to A=0x10 during ADD and during DONE -> single Done; Sum=0x03; Busy stays 1 until the edge after Done.
- Reset asserted at the 4th ADD edge -> next cycle Busy=0, Done=0, Sum=0x00; no Done for 20 cycles. A fresh Start with A=0x07, B=0x09 then gives Sum=0x10.
- Start held high with 50 random operand/CarryIn triples changed each IDLE cycle -> each Done matches the reference sum and flags; exactly one IDLE cycle separates consecutive operations.
